div_sequencer: RTL and testbench
================================

Name: div_sequencer

Overview:
Multi-cycle controller for the integer divide/remainder path of the execute stage. It covers RV64M DIV/DIVU/REM/REMU and the W variants, using a radix-2 restoring iteration. On each accepted request it stalls the front of the pipeline, iterates, fixes signs, then presents one result to the execute-to-memory pipeline register. Branch-mispredict flush and memory-stage stall are honoured.

Parameters:
DATA_WIDTH, 64, operand/result width; iteration count is DATA_WIDTH for full ops, 32 for W ops.

Ports:
i_clk  in  1  clock, rising edge
i_arst  in  1  reset, synchronous, active-high
i_start  in  1  execute stage holds a valid div/rem op this cycle
i_func3  in  3  3'd4 DIV, 3'd5 DIVU, 3'd6 REM, 3'd7 REMU
i_word  in  1  W variant: operate on [31:0], sign-extend result
i_src_1  in  DATA_WIDTH  dividend (post-forwarding)
i_src_2  in  DATA_WIDTH  divisor (post-forwarding)
i_flush  in  1  kill in-flight op (mispredict)
i_stall_mem  in  1  downstream not accepting; hold result
o_stall_exec  out  1  freeze fetch/decode/execute
o_done  out  1  o_result valid this cycle
o_result  out  DATA_WIDTH  quotient or remainder

Behaviour:
- Reset (i_arst=1 at a clock edge): state IDLE; counter, quotient, remainder and divisor registers cleared to 0; o_done=0; o_result=0; o_stall_exec=0.
- States: IDLE, CALC, FIXUP, DONE.
- IDLE, accept condition i_start=1 and i_flush=0:
  - Latch operands and op.
  - Record negate-quotient flag = signed op and signs differ.
  - Record negate-remainder flag = signed op and dividend negative.
  - Load |dividend| and |divisor|. For W ops use the sign-extended or zero-extended low 32 bits.
  - Set counter to 64 for full ops, 32 for W ops.
  - Divisor zero: go straight to DONE with the special result.
  - Signed overflow (MIN / -1, at the 32- or 64-bit width): go straight to DONE with the special result.
  - Otherwise go to CALC.
- CALC, one iteration per cycle:
  - Shift {rem,quo} left 1 and compute trial = rem - divisor.
  - If trial is non-negative, keep it and set quotient LSB to 1.
  - Decrement counter. When it reaches 1 in this cycle, go to FIXUP.
- FIXUP: apply the negation flags. For W ops sign-extend bit 31 of the selected value to DATA_WIDTH. Register the selected result into o_result. Go to DONE.
- DONE: o_done=1.
  - i_stall_mem=1: stay in DONE, o_result stable.
  - Else: go to IDLE next cycle.
- Special results:
  - Divide by zero: quotient all-ones; remainder = dividend. For W ops both are sign-extended from 32 bits.
  - Signed overflow: quotient = dividend; remainder 0.
- o_stall_exec = (IDLE & i_start & ~i_flush) | CALC | FIXUP. It is 0 in DONE so the op advances.
- Latency, with acceptance at cycle T:
  - Full op: DONE at T+66.
  - W op: DONE at T+34.
  - Special case: DONE at T+1.
- i_flush in any state: IDLE next cycle, o_done=0 from then on. A start in the same cycle as a flush is ignored. Flush takes priority over i_stall_mem.
- i_start outside IDLE is ignored. The op is held frozen upstream by o_stall_exec.
- Arithmetic:
  - The remainder register is DATA_WIDTH+1 bits so the trial subtract never overflows.
  - Two's-complement negation wraps modulo 2^DATA_WIDTH.
  - |MIN| is represented as unsigned MIN.
- Reset mid-operation: immediate return to reset state with no o_done pulse. Reset dominates flush and start.

Decomposition:
- Package div_pkg:
  - div_state_t enum (IDLE, CALC, FIXUP, DONE).
  - Localparams for the func3 codes DIV=4, DIVU=5, REM=6, REMU=7.
  - Localparams for iteration counts 64 and 32.
- Sub-module div_step: combinational single restoring iteration.
  - Inputs: rem, quo, divisor.
  - Outputs: next rem, next quo.
  - Instantiated once by div_sequencer, which owns the FSM, counter, sign fix-up and special-case logic.

Test Plan:
- DIV 100 / 7, i_word=0, accepted at T -> o_stall_exec=1 T..T+65, o_done=1 at T+66, o_result=14; DONE lasts 1 cycle.
- REM -100 / 7 (signed) -> o_result=-2 (0xFFFF_FFFF_FFFF_FFFE); REMU 0xFFFF_FFFF_FFFF_FFFF / 16 -> 15.
- DIVUW 0x1_8000_0000 / 1 (i_word=1) -> o_done at T+34, o_result=0xFFFF_FFFF_8000_0000.
- DIV x / 0 -> o_done at T+1, o_result=0xFFFF_FFFF_FFFF_FFFF; REM 0x8000_0000_0000_0000 / -1 -> o_done at T+1, o_result=0.
- Full DIV in progress, i_flush=1 at T+20 -> IDLE at T+21, o_stall_exec=0, no o_done; a new i_start at T+21 completes normally at T+87.
- i_stall_mem=1 during DONE for 3 cycles -> o_done and o_result held 4 cycles total, then IDLE; i_arst asserted during CALC -> all outputs 0 next cycle.

Source files
------------

// File: rtl/div_pkg.sv
// Shared types and constants for the execute-stage integer divide/remainder sequencer.
package div_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIXUP,
        DONE
    } div_state_t;

    localparam logic [2:0] FUNC3_DIV  = 3'd4;
    localparam logic [2:0] FUNC3_DIVU = 3'd5;
    localparam logic [2:0] FUNC3_REM  = 3'd6;
    localparam logic [2:0] FUNC3_REMU = 3'd7;

    localparam int ITER_FULL = 64;
    localparam int ITER_WORD = 32;

endpackage

// File: rtl/div_sequencer_if.sv
// Request/response bundle between the execute stage and the divide sequencer.
interface div_sequencer_if #(
    parameter int DATA_WIDTH = 64
);
    logic                  i_start;
    logic [2:0]            i_func3;
    logic                  i_word;
    logic [DATA_WIDTH-1:0] i_src_1;
    logic [DATA_WIDTH-1:0] i_src_2;
    logic                  i_flush;
    logic                  i_stall_mem;
    logic                  o_stall_exec;
    logic                  o_done;
    logic [DATA_WIDTH-1:0] o_result;

    modport master (
        output i_start, i_func3, i_word, i_src_1, i_src_2, i_flush, i_stall_mem,
        input  o_stall_exec, o_done, o_result
    );

    modport slave (
        input  i_start, i_func3, i_word, i_src_1, i_src_2, i_flush, i_stall_mem,
        output o_stall_exec, o_done, o_result
    );
endinterface

// File: rtl/div_step.sv
// One radix-2 restoring division iteration on magnitudes; purely combinational.
module div_step #(
    parameter int DATA_WIDTH = 64
) (
    input  logic [DATA_WIDTH:0]   rem,
    input  logic [DATA_WIDTH-1:0] quo,
    input  logic [DATA_WIDTH-1:0] divisor,
    output logic [DATA_WIDTH:0]   next_rem,
    output logic [DATA_WIDTH-1:0] next_quo
);
    // One extra bit on top of the remainder makes the trial's sign bit unambiguous.
    logic [DATA_WIDTH+1:0] shifted;
    logic [DATA_WIDTH+1:0] trial;

    always_comb begin
        shifted = {rem, quo[DATA_WIDTH-1]};
        trial   = shifted - {2'b00, divisor};
        if (trial[DATA_WIDTH+1]) begin
            next_rem = shifted[DATA_WIDTH:0];
            next_quo = {quo[DATA_WIDTH-2:0], 1'b0};
        end else begin
            next_rem = trial[DATA_WIDTH:0];
            next_quo = {quo[DATA_WIDTH-2:0], 1'b1};
        end
    end
endmodule

// File: rtl/div_sequencer.sv
// Multi-cycle DIV/DIVU/REM/REMU (+W) controller: stalls execute, iterates, fixes signs,
// then holds one result for the execute-to-memory register.
module div_sequencer
    import div_pkg::*;
#(
    parameter int DATA_WIDTH = ITER_FULL
) (
    input  logic           i_clk,
    input  logic           i_arst,
    div_sequencer_if.slave bus
);
    localparam int CW = $clog2(DATA_WIDTH + 1);
    typedef logic [DATA_WIDTH-1:0] word_t;

    div_state_t          state;
    logic [CW-1:0]       count;
    logic [DATA_WIDTH:0] rem_q;
    word_t               quo_q;
    word_t               divisor_q;
    logic                op_rem;
    logic                op_word;
    logic                neg_quo;
    logic                neg_rem;
    logic                done_q;
    word_t               result_q;

    logic                op_signed_in;
    logic                op_rem_in;
    word_t               src_a;
    word_t               src_b;
    word_t               abs_a;
    word_t               abs_b;
    word_t               min_val;
    word_t               dividend_res;
    word_t               special_res;
    word_t               quo_load;
    logic                a_neg;
    logic                b_neg;
    logic                div_zero;
    logic                overflow;
    logic                accept;
    logic [DATA_WIDTH:0] next_rem;
    word_t               next_quo;
    word_t               sel_val;
    word_t               fix_val;
    word_t               fix_res;

    function automatic word_t sext32(input logic [31:0] v);
        return {{(DATA_WIDTH-32){v[31]}}, v};
    endfunction

    // NOTE: every signal is assigned on every path through this block, so no latch is inferred.
    always_comb begin
        op_signed_in = (bus.i_func3 == FUNC3_DIV) || (bus.i_func3 == FUNC3_REM);
        op_rem_in    = (bus.i_func3 == FUNC3_REM) || (bus.i_func3 == FUNC3_REMU);
        if (bus.i_word) begin
            src_a        = op_signed_in ? sext32(bus.i_src_1[31:0]) : word_t'(bus.i_src_1[31:0]);
            src_b        = op_signed_in ? sext32(bus.i_src_2[31:0]) : word_t'(bus.i_src_2[31:0]);
            min_val      = sext32(32'h8000_0000);
            dividend_res = sext32(bus.i_src_1[31:0]);
        end else begin
            src_a        = bus.i_src_1;
            src_b        = bus.i_src_2;
            min_val      = {1'b1, {(DATA_WIDTH-1){1'b0}}};
            dividend_res = bus.i_src_1;
        end
        a_neg    = op_signed_in & src_a[DATA_WIDTH-1];
        b_neg    = op_signed_in & src_b[DATA_WIDTH-1];
        abs_a    = a_neg ? -src_a : src_a;
        abs_b    = b_neg ? -src_b : src_b;
        div_zero = (src_b == '0);
        overflow = op_signed_in && (src_a == min_val) && (src_b == '1);
        // W dividends sit in the top 32 bits so 32 iterations leave the quotient in [31:0].
        quo_load = bus.i_word ? {abs_a[31:0], {(DATA_WIDTH-32){1'b0}}} : abs_a;

        if (div_zero) begin
            special_res = op_rem_in ? dividend_res : '1;
        end else begin
            special_res = op_rem_in ? '0 : dividend_res;
        end

        accept  = (state == IDLE) && bus.i_start && !bus.i_flush;
        sel_val = op_rem ? rem_q[DATA_WIDTH-1:0] : quo_q;
        fix_val = (op_rem ? neg_rem : neg_quo) ? -sel_val : sel_val;
        fix_res = op_word ? sext32(fix_val[31:0]) : fix_val;
    end

    div_step #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_step (
        .rem      (rem_q),
        .quo      (quo_q),
        .divisor  (divisor_q),
        .next_rem (next_rem),
        .next_quo (next_quo)
    );

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge i_clk) begin
        if (i_arst) begin
            state     <= IDLE;
            count     <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            divisor_q <= '0;
            op_rem    <= 1'b0;
            op_word   <= 1'b0;
            neg_quo   <= 1'b0;
            neg_rem   <= 1'b0;
            done_q    <= 1'b0;
            result_q  <= '0;
        end else if (bus.i_flush) begin
            state  <= IDLE;
            done_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.i_start) begin
                        op_rem    <= op_rem_in;
                        op_word   <= bus.i_word;
                        neg_quo   <= a_neg ^ b_neg;
                        neg_rem   <= a_neg;
                        rem_q     <= '0;
                        quo_q     <= quo_load;
                        divisor_q <= abs_b;
                        count     <= bus.i_word ? CW'(ITER_WORD) : CW'(DATA_WIDTH);
                        if (div_zero || overflow) begin
                            result_q <= special_res;
                            done_q   <= 1'b1;
                            state    <= DONE;
                        end else begin
                            state <= CALC;
                        end
                    end
                end
                CALC: begin
                    rem_q <= next_rem;
                    quo_q <= next_quo;
                    count <= count - CW'(1);
                    if (count == CW'(1)) begin
                        state <= FIXUP;
                    end
                end
                FIXUP: begin
                    result_q <= fix_res;
                    done_q   <= 1'b1;
                    state    <= DONE;
                end
                DONE: begin
                    if (!bus.i_stall_mem) begin
                        done_q <= 1'b0;
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.o_stall_exec = accept || (state == CALC) || (state == FIXUP);
    assign bus.o_done       = done_q;
    assign bus.o_result     = result_q;
endmodule

// File: tb/tb_div_sequencer.sv
// Directed bench for div_sequencer: a table of hand-computed ops plus flush, mem-stall
// and reset sequences.
module tb_div_sequencer;
    import div_pkg::*;

    typedef struct {
        logic [2:0]  func3;
        logic        word;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] exp;
        int          lat;
        string       name;
    } vec_t;

    logic clk;
    logic arst;
    int   vectors;
    int   miscompares;
    vec_t vecs[$];

    div_sequencer_if #(.DATA_WIDTH(64)) bus ();

    div_sequencer #(.DATA_WIDTH(64)) dut (
        .i_clk  (clk),
        .i_arst (arst),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%h, expected 0x%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic add_vec(input logic [2:0] f3, input logic w, input logic [63:0] a,
                           input logic [63:0] b, input logic [63:0] exp, input int lat,
                           input string name);
        vec_t v;
        v.func3 = f3; v.word = w; v.a = a; v.b = b; v.exp = exp; v.lat = lat; v.name = name;
        vecs.push_back(v);
    endtask

    task automatic set_op(input logic [2:0] f3, input logic w, input logic [63:0] a,
                          input logic [63:0] b);
        bus.i_func3 = f3;
        bus.i_word  = w;
        bus.i_src_1 = a;
        bus.i_src_2 = b;
        bus.i_start = 1'b1;
    endtask

    // Ticks until o_done, with a bound; n returns the cycles waited.
    task automatic wait_done(input int max_cycles, output int n, output int gaps);
        n    = 0;
        gaps = 0;
        while (n < max_cycles) begin
            tick();
            n++;
            if (bus.o_done) break;
            if (!bus.o_stall_exec) gaps++;
        end
    endtask

    task automatic run_op(input logic [2:0] f3, input logic w, input logic [63:0] a,
                          input logic [63:0] b, input logic [63:0] exp, input int lat,
                          input string name);
        int n;
        int gaps;
        set_op(f3, w, a, b);
        #1;
        check({name, "_stall_at_accept"}, 64'(bus.o_stall_exec), 64'd1);
        wait_done(200, n, gaps);
        check({name, "_latency"}, 64'(n), 64'(lat));
        check({name, "_result"}, bus.o_result, exp);
        check({name, "_stall_gaps"}, 64'(gaps), 64'd0);
        check({name, "_stall_in_done"}, 64'(bus.o_stall_exec), 64'd0);
        bus.i_start = 1'b0;
        tick();
        check({name, "_done_one_cycle"}, 64'(bus.o_done), 64'd0);
    endtask

    initial begin
        int n;
        int gaps;
        vectors     = 0;
        miscompares = 0;
        arst            = 1'b1;
        bus.i_start     = 1'b0;
        bus.i_func3     = 3'd0;
        bus.i_word      = 1'b0;
        bus.i_src_1     = '0;
        bus.i_src_2     = '0;
        bus.i_flush     = 1'b0;
        bus.i_stall_mem = 1'b0;

        add_vec(FUNC3_DIV,  1'b0, 64'd100, 64'd7, 64'd14, 66, "div_100_7");
        add_vec(FUNC3_REM,  1'b0, 64'hFFFF_FFFF_FFFF_FF9C, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 66, "rem_m100_7");
        add_vec(FUNC3_REMU, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd16, 64'd15, 66, "remu_max_16");
        add_vec(FUNC3_DIVU, 1'b1, 64'h0000_0001_8000_0000, 64'd1, 64'hFFFF_FFFF_8000_0000, 34, "divuw_msb");
        add_vec(FUNC3_DIV,  1'b0, 64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1, "div_by_zero");
        add_vec(FUNC3_REM,  1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1, "rem_overflow");
        add_vec(FUNC3_DIV,  1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 1, "div_overflow");
        add_vec(FUNC3_REMU, 1'b0, 64'd123, 64'd0, 64'd123, 1, "remu_by_zero");
        add_vec(FUNC3_DIV,  1'b1, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 34, "divw_m7_2");
        add_vec(FUNC3_REM,  1'b1, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 34, "remw_m7_2");
        add_vec(FUNC3_DIV,  1'b0, 64'hFFFF_FFFF_FFFF_FF9C, 64'hFFFF_FFFF_FFFF_FFF9, 64'd14, 66, "div_m100_m7");
        add_vec(FUNC3_DIV,  1'b1, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, 64'hFFFF_FFFF_8000_0000, 1, "divw_overflow");
        add_vec(FUNC3_REMU, 1'b1, 64'h0000_0000_FFFF_FFFF, 64'h0000_0001_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1, "remuw_by_zero");
        add_vec(FUNC3_DIVU, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 66, "divu_max_1");
        add_vec(FUNC3_REM,  1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 64'd1, 66, "rem_7_m3");
        add_vec(FUNC3_DIV,  1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFFE, 66, "div_7_m3");

        tick();
        tick();
        arst = 1'b0;
        check("reset_done", 64'(bus.o_done), 64'd0);
        check("reset_result", bus.o_result, 64'd0);
        check("reset_stall", 64'(bus.o_stall_exec), 64'd0);

        foreach (vecs[i]) begin
            run_op(vecs[i].func3, vecs[i].word, vecs[i].a, vecs[i].b, vecs[i].exp,
                   vecs[i].lat, vecs[i].name);
        end

        // Flush mid-CALC, then a fresh op right after.
        set_op(FUNC3_DIV, 1'b0, 64'd100, 64'd7);
        for (int i = 0; i < 20; i++) tick();
        check("flush_pre_stall", 64'(bus.o_stall_exec), 64'd1);
        bus.i_flush = 1'b1;
        tick();
        bus.i_flush = 1'b0;
        bus.i_start = 1'b0;
        #1;
        check("flush_idle_stall", 64'(bus.o_stall_exec), 64'd0);
        check("flush_no_done", 64'(bus.o_done), 64'd0);
        run_op(FUNC3_DIV, 1'b0, 64'd1000, 64'd10, 64'd100, 66, "after_flush");

        // Start together with flush is ignored (div-by-zero would otherwise finish next cycle).
        set_op(FUNC3_DIV, 1'b0, 64'd9, 64'd0);
        bus.i_flush = 1'b1;
        #1;
        check("start_flush_stall", 64'(bus.o_stall_exec), 64'd0);
        tick();
        bus.i_start = 1'b0;
        bus.i_flush = 1'b0;
        check("start_flush_no_done", 64'(bus.o_done), 64'd0);
        tick();
        check("start_flush_no_done2", 64'(bus.o_done), 64'd0);

        // Memory stall holds DONE and the result.
        set_op(FUNC3_DIV, 1'b0, 64'd100, 64'd7);
        wait_done(200, n, gaps);
        check("memstall_latency", 64'(n), 64'd66);
        bus.i_start     = 1'b0;
        bus.i_stall_mem = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            tick();
            check($sformatf("memstall_done_%0d", i), 64'(bus.o_done), 64'd1);
            check($sformatf("memstall_result_%0d", i), bus.o_result, 64'd14);
        end
        bus.i_stall_mem = 1'b0;
        tick();
        check("memstall_release", 64'(bus.o_done), 64'd0);
        check("memstall_idle_stall", 64'(bus.o_stall_exec), 64'd0);

        // Reset during CALC.
        set_op(FUNC3_DIVU, 1'b0, 64'd77, 64'd3);
        for (int i = 0; i < 10; i++) tick();
        bus.i_start = 1'b0;
        arst        = 1'b1;
        tick();
        arst = 1'b0;
        check("calc_reset_done", 64'(bus.o_done), 64'd0);
        check("calc_reset_result", bus.o_result, 64'd0);
        check("calc_reset_stall", 64'(bus.o_stall_exec), 64'd0);
        for (int i = 0; i < 70; i++) begin
            tick();
            if (bus.o_done) break;
        end
        check("calc_reset_no_late_done", 64'(bus.o_done), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
